// File: rtl/pc_seq_if.sv
// Decode-to-fetch control bundle for the PC sequencer: jump/branch/trap requests in,
// fetch address and downstream strobes out.
interface pc_seq_if;
    logic        stall;
    logic        jump_valid;
    logic [25:0] jump_index;
    logic        jump_link;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        exception;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] link_addr;
    logic        link_we;
    logic        flush;
    logic        fetch_valid;
    logic        misaligned;
    logic [1:0]  state_dbg;

    // Requests are single-cycle qualifiers sampled on every rising edge. There is no
    // ready/backpressure: a request the sequencer does not honour that cycle is dropped.
    modport master (
        output stall, jump_valid, jump_index, jump_link, jr_valid, jr_target,
               branch_taken, branch_offset, exception, halt,
        input  pc, pc_plus4, link_addr, link_we, flush, fetch_valid, misaligned, state_dbg
    );

    modport slave (
        input  stall, jump_valid, jump_index, jump_link, jr_valid, jr_target,
               branch_taken, branch_offset, exception, halt,
        output pc, pc_plus4, link_addr, link_we, flush, fetch_valid, misaligned, state_dbg
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC owner for the MIPS core: sequential fetch, J/JAL/JR/branch redirects,
// stall, halt and exception handling with a post-redirect fetch bubble.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR       = 32'h0000_0080,
    parameter int unsigned REDIRECT_BUBBLES = 1
) (
    input logic     clk,
    input logic     rst_n,
    pc_seq_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0] BUBBLE_INIT = 2'(REDIRECT_BUBBLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] link_q, link_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        link_we_q, link_we_d;
    logic        mis_q, mis_d;
    logic [31:0] pc_plus4;
    logic [31:0] jump_tgt;
    logic [31:0] branch_tgt;
    logic        redirect;
    logic [31:0] redirect_tgt;

    assign pc_plus4   = pc_q + 32'd4;
    // J/JAL region comes from pc+4 so a jump in the last slot of a 256MB region lands in the next.
    assign jump_tgt   = {pc_plus4[31:28], bus.jump_index, 2'b00};
    assign branch_tgt = pc_plus4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        link_d       = link_q;
        flush_d      = 1'b0;
        link_we_d    = 1'b0;
        mis_d        = 1'b0;
        redirect     = 1'b0;
        redirect_tgt = EXC_VECTOR;
        if (bus.exception) begin
            redirect = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (!bus.stall) begin
                        if (bus.jr_valid) begin
                            redirect = 1'b1;
                            if (bus.jr_target[1:0] != 2'b00) mis_d = 1'b1;
                            else redirect_tgt = bus.jr_target;
                        end else if (bus.jump_valid) begin
                            redirect     = 1'b1;
                            redirect_tgt = jump_tgt;
                            if (bus.jump_link) begin
                                link_we_d = 1'b1;
                                link_d    = pc_plus4;
                            end
                        end else if (bus.branch_taken) begin
                            redirect     = 1'b1;
                            redirect_tgt = branch_tgt;
                        end else if (bus.halt) begin
                            state_d = HALTED;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end
                BUBBLE: begin
                    // pc stays on the target; the first valid fetch is the target itself.
                    if (cnt_q == 2'd0) state_d = RUN;
                    else cnt_d = cnt_q - 2'd1;
                end
                HALTED:  state_d = HALTED;
                default: state_d = RUN;
            endcase
        end
        if (redirect) begin
            pc_d    = redirect_tgt;
            state_d = BUBBLE;
            cnt_d   = BUBBLE_INIT;
            flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_VECTOR;
            cnt_q     <= 2'd0;
            link_q    <= 32'd0;
            flush_q   <= 1'b0;
            link_we_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            link_q    <= link_d;
            flush_q   <= flush_d;
            link_we_q <= link_we_d;
            mis_q     <= mis_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.link_addr   = link_q;
    assign bus.link_we     = link_we_q;
    assign bus.flush       = flush_q;
    assign bus.fetch_valid = (state_q == RUN);
    assign bus.misaligned  = mis_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the fetch sequencing rules.
module tb_pc_sequencer;
    localparam logic [31:0] RST_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC = 32'h0000_0080;
    localparam int          NBUB    = 1;
    localparam int          W       = 100;

    logic clk;
    logic rst_n;
    pc_seq_if bus ();

    pc_sequencer #(
        .RESET_VECTOR    (RST_VEC),
        .EXC_VECTOR      (EXC_VEC),
        .REDIRECT_BUBBLES(NBUB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    logic [W-1:0] exp_q[$];

    // behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_link;
    bit          m_halted;
    int          m_bub_left;
    bit          m_flush, m_lwe, m_mis;

    function automatic logic [W-1:0] model_vec();
        return {m_pc, m_pc + 32'd4, m_link, m_lwe, m_flush,
                (!m_halted && m_bub_left == 0), m_mis};
    endfunction

    function automatic logic [W-1:0] obs_vec();
        return {bus.pc, bus.pc_plus4, bus.link_addr, bus.link_we, bus.flush,
                bus.fetch_valid, bus.misaligned};
    endfunction

    task automatic model_reset();
        m_pc = RST_VEC; m_link = 32'd0; m_halted = 0; m_bub_left = 0;
        m_flush = 0; m_lwe = 0; m_mis = 0;
    endtask

    // One clock of the sequencing rules, using the inputs currently applied.
    task automatic model_step();
        logic [31:0] p4;
        logic [31:0] tgt;
        bit go;
        p4 = m_pc + 32'd4;
        tgt = EXC_VEC;
        go = 0;
        m_flush = 0; m_lwe = 0; m_mis = 0;
        if (bus.exception) go = 1;
        else if (m_halted) begin end
        else if (m_bub_left > 0) m_bub_left--;
        else if (!bus.stall) begin
            if (bus.jr_valid) begin
                go = 1;
                if (bus.jr_target % 4 != 0) m_mis = 1;
                else tgt = bus.jr_target;
            end else if (bus.jump_valid) begin
                go = 1;
                tgt = (p4 & 32'hF000_0000) | (32'(bus.jump_index) * 4);
                if (bus.jump_link) begin m_lwe = 1; m_link = p4; end
            end else if (bus.branch_taken) begin
                go = 1;
                tgt = p4 + 32'($signed(bus.branch_offset) * 4);
            end else if (bus.halt) m_halted = 1;
            else m_pc = p4;
        end
        if (go) begin
            m_pc = tgt; m_halted = 0; m_flush = 1; m_bub_left = NBUB;
        end
    endtask

    // driver tasks
    task automatic clear_inputs();
        bus.stall = 0; bus.jump_valid = 0; bus.jump_index = '0; bus.jump_link = 0;
        bus.jr_valid = 0; bus.jr_target = '0; bus.branch_taken = 0;
        bus.branch_offset = '0; bus.exception = 0; bus.halt = 0;
    endtask

    task automatic step();
        model_step();
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        rst_n = 1'b1;
    endtask

    // Reset, then JR to addr and let the bubble drain so pc=addr in RUN.
    task automatic goto(input logic [31:0] addr);
        clear_inputs();
        reset_pulse();
        bus.jr_valid = 1; bus.jr_target = addr;
        step();
        clear_inputs();
        step();
        exp_q.delete();
    endtask

    task automatic test_reset();
        goto(32'h0000_1234);
        total++; if (bus.pc !== 32'h0000_1234) $display("FAIL goto_1234 pc got %h exp %h", bus.pc, 32'h1234); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.pc !== RST_VEC) $display("FAIL async_reset pc got %h exp %h", bus.pc, RST_VEC); else passed++;
        total++; if ({bus.fetch_valid, bus.flush, bus.link_we, bus.misaligned, bus.link_addr} !== {4'b1000, 32'd0})
            $display("FAIL async_reset outs got %b/%h exp 1000/0", {bus.fetch_valid, bus.flush, bus.link_we, bus.misaligned}, bus.link_addr);
        else passed++;
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (bus.pc !== 32'(4 * i) || bus.fetch_valid !== 1'b1)
                $display("FAIL reset_seq%0d pc/fv got %h/%b exp %h/1", i, bus.pc, bus.fetch_valid, 32'(4 * i));
            else passed++;
        end
        // reset asserted mid-bubble returns to RUN immediately
        bus.jump_valid = 1; bus.jump_index = 26'h100;
        step();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        total++; if ({bus.fetch_valid, bus.flush, bus.pc} !== {2'b10, RST_VEC})
            $display("FAIL reset_in_bubble fv/flush/pc got %b%b/%h exp 10/%h", bus.fetch_valid, bus.flush, bus.pc, RST_VEC);
        else passed++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_jump();
        goto(32'h8000_0010);
        bus.jump_valid = 1; bus.jump_index = 26'h40;
        step();
        clear_inputs();
        total++; if ({bus.pc, bus.flush, bus.fetch_valid} !== {32'h8000_0100, 2'b10})
            $display("FAIL jump_redirect pc/flush/fv got %h/%b/%b exp 80000100/1/0", bus.pc, bus.flush, bus.fetch_valid);
        else passed++;
        step();
        total++; if ({bus.pc, bus.flush, bus.fetch_valid} !== {32'h8000_0100, 2'b01})
            $display("FAIL jump_bubble_end pc/flush/fv got %h/%b/%b exp 80000100/0/1", bus.pc, bus.flush, bus.fetch_valid);
        else passed++;
        step();
        total++; if (bus.pc !== 32'h8000_0104) $display("FAIL jump_next pc got %h exp 80000104", bus.pc); else passed++;
    endtask

    task automatic test_region();
        goto(32'h0FFF_FFFC);
        bus.jump_valid = 1; bus.jump_index = 26'h1;
        step();
        clear_inputs();
        total++; if (bus.pc !== 32'h1000_0004) $display("FAIL jump_region pc got %h exp 10000004", bus.pc); else passed++;
        goto(32'hFFFF_FFFC);
        total++; if (bus.pc_plus4 !== 32'h0) $display("FAIL pc_plus4_wrap got %h exp 00000000", bus.pc_plus4); else passed++;
        step();
        total++; if (bus.pc !== 32'h0) $display("FAIL seq_wrap pc got %h exp 00000000", bus.pc); else passed++;
    endtask

    task automatic test_branch_priority();
        goto(32'h0000_0100);
        bus.branch_taken = 1; bus.branch_offset = 16'hFFFF;
        step();
        clear_inputs();
        total++; if (bus.pc !== 32'h0000_0100 || bus.flush !== 1'b1)
            $display("FAIL branch_back pc/flush got %h/%b exp 00000100/1", bus.pc, bus.flush);
        else passed++;
        step();
        bus.jump_valid = 1; bus.jump_index = 26'h200; bus.branch_taken = 1; bus.branch_offset = 16'h0010;
        step();
        clear_inputs();
        total++; if (bus.pc !== 32'h0000_0800) $display("FAIL jump_over_branch pc got %h exp 00000800", bus.pc); else passed++;
    endtask

    task automatic test_jal();
        goto(32'h8000_0010);
        bus.jump_valid = 1; bus.jump_link = 1; bus.jump_index = 26'h40;
        step();
        clear_inputs();
        total++; if ({bus.link_we, bus.flush, bus.link_addr} !== {2'b11, 32'h8000_0014})
            $display("FAIL jal_link we/flush/addr got %b/%b/%h exp 1/1/80000014", bus.link_we, bus.flush, bus.link_addr);
        else passed++;
        step();
        total++; if (bus.link_we !== 1'b0 || bus.link_addr !== 32'h8000_0014)
            $display("FAIL jal_pulse we/addr got %b/%h exp 0/80000014", bus.link_we, bus.link_addr);
        else passed++;
        goto(32'h8000_0010);
        bus.stall = 1; bus.jump_valid = 1; bus.jump_link = 1; bus.jump_index = 26'h40;
        step();
        clear_inputs();
        total++; if ({bus.link_we, bus.flush, bus.pc} !== {2'b00, 32'h8000_0010})
            $display("FAIL jal_stalled we/flush/pc got %b/%b/%h exp 0/0/80000010", bus.link_we, bus.flush, bus.pc);
        else passed++;
        step();
        total++; if (bus.pc !== 32'h8000_0014) $display("FAIL jal_dropped pc got %h exp 80000014", bus.pc); else passed++;
    endtask

    task automatic test_jr_exception();
        goto(32'h0000_0000);
        bus.jr_valid = 1; bus.jr_target = 32'h0000_0042;
        step();
        clear_inputs();
        total++; if ({bus.pc, bus.misaligned, bus.flush} !== {EXC_VEC, 2'b11})
            $display("FAIL jr_misaligned pc/mis/flush got %h/%b/%b exp %h/1/1", bus.pc, bus.misaligned, bus.flush, EXC_VEC);
        else passed++;
        step();
        total++; if (bus.misaligned !== 1'b0) $display("FAIL mis_pulse got %b exp 0", bus.misaligned); else passed++;
        goto(32'h0000_0200);
        bus.stall = 1; bus.exception = 1;
        step();
        clear_inputs();
        total++; if (bus.pc !== EXC_VEC || bus.flush !== 1'b1)
            $display("FAIL exc_stalled pc/flush got %h/%b exp %h/1", bus.pc, bus.flush, EXC_VEC);
        else passed++;
        goto(32'h0000_0300);
        bus.halt = 1;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.pc !== 32'h0000_0300 || bus.fetch_valid !== 1'b0)
                $display("FAIL halted%0d pc/fv got %h/%b exp 00000300/0", i, bus.pc, bus.fetch_valid);
            else passed++;
            bus.jump_valid = (i == 1);
            step();
            clear_inputs();
        end
        bus.exception = 1;
        step();
        clear_inputs();
        total++; if ({bus.pc, bus.flush, bus.fetch_valid} !== {EXC_VEC, 2'b10})
            $display("FAIL exc_halted pc/flush/fv got %h/%b/%b exp %h/1/0", bus.pc, bus.flush, bus.fetch_valid, EXC_VEC);
        else passed++;
        step();
        total++; if (bus.fetch_valid !== 1'b1 || bus.pc !== EXC_VEC)
            $display("FAIL exc_resume pc/fv got %h/%b exp %h/1", bus.pc, bus.fetch_valid, EXC_VEC);
        else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] exp;
        logic [W-1:0] got;
        clear_inputs();
        reset_pulse();
        for (int i = 0; i < 400; i++) begin
            bus.stall         = ($urandom_range(0, 99) < 20);
            bus.exception     = ($urandom_range(0, 99) < 3);
            bus.halt          = ($urandom_range(0, 99) < 3);
            bus.jr_valid      = ($urandom_range(0, 99) < 8);
            bus.jr_target     = $urandom;
            if ($urandom_range(0, 3) != 0) bus.jr_target[1:0] = 2'b00;
            bus.jump_valid    = ($urandom_range(0, 99) < 12);
            bus.jump_link     = $urandom_range(0, 1);
            bus.jump_index    = 26'($urandom);
            bus.branch_taken  = ($urandom_range(0, 99) < 12);
            bus.branch_offset = 16'($urandom);
            step();
            exp = exp_q.pop_front();
            got = obs_vec();
            total++;
            if (got !== exp) $display("FAIL random_cyc%0d got %h exp %h", i, got, exp);
            else passed++;
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #2 rst_n = 1'b1;
        test_reset();
        test_jump();
        test_region();
        test_branch_priority();
        test_jal();
        test_jr_exception();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
